mem_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer for the 8-word x 256-bit matrix memory.

---
 rtl/mem_arbiter_if.sv | 39 +++
 rtl/mem_arbiter.sv | 137 +++++++++++++
 tb/tb_mem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-pin bundle between the two requesters, mem_arbiter and the memory.
// Handshake: a requester raises reqN with weN/addrN/wdataN stable and holds it until ackN pulses
// for one cycle; err and rdata are valid in that ack cycle, and req is only sampled while idle.
interface mem_arbiter_if #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 4
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic              err;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic              mem_nEnable;
    logic              mem_ReadWrite;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_wdata_oe;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, err, rdata, busy,
        output mem_nEnable, mem_ReadWrite, mem_address, mem_wdata, mem_wdata_oe
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, err, rdata, busy,
        input  mem_nEnable, mem_ReadWrite, mem_address, mem_wdata, mem_wdata_oe
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the matrix memory: one single-word
// transaction at a time, IDLE -> ACCESS -> [WAIT_RD] -> DONE, all outputs registered.
module mem_arbiter #(
    parameter int DATA_W = 256,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 8,
    parameter int RD_LAT = 1
) (
    input  logic         clk,
    input  logic         reset,
    mem_arbiter_if.slave bus,
    output logic [1:0]   stateDbg
);
    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        WAIT_RD = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state;
    state_t            nextState;
    logic              lastGrant;
    logic              curPort;
    logic              curWe;
    logic [CNT_W-1:0]  waitCnt;

    logic              anyReq;
    logic              grantPort;
    logic              selWe;
    logic [ADDR_W-1:0] selAddr;
    logic [DATA_W-1:0] selWdata;
    logic              selErr;
    logic              donePort;

    logic              nEnableD;
    logic              readWriteD;
    logic [ADDR_W-1:0] addressD;
    logic [DATA_W-1:0] wdataD;
    logic              wdataOeD;
    logic              ack0D;
    logic              ack1D;
    logic              errD;
    logic [DATA_W-1:0] rdataD;

    // Contention goes to the port that did not win last time.
    assign anyReq    = bus.req0 || bus.req1;
    assign grantPort = (bus.req0 && bus.req1) ? ~lastGrant : bus.req1;
    assign selWe     = grantPort ? bus.we1    : bus.we0;
    assign selAddr   = grantPort ? bus.addr1  : bus.addr0;
    assign selWdata  = grantPort ? bus.wdata1 : bus.wdata0;
    assign selErr    = 32'(selAddr) >= 32'(DEPTH);
    assign donePort  = (state == IDLE) ? grantPort : curPort;
    assign stateDbg  = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            lastGrant         <= 1'b1;
            curPort           <= 1'b0;
            curWe             <= 1'b0;
            waitCnt           <= '0;
            bus.mem_nEnable   <= 1'b1;
            bus.mem_ReadWrite <= 1'b1;
            bus.mem_address   <= '0;
            bus.mem_wdata     <= '0;
            bus.mem_wdata_oe  <= 1'b0;
            bus.ack0          <= 1'b0;
            bus.ack1          <= 1'b0;
            bus.err           <= 1'b0;
            bus.rdata         <= '0;
            bus.busy          <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE && anyReq) begin
                lastGrant <= grantPort;
                curPort   <= grantPort;
                curWe     <= selWe;
            end
            if (state == ACCESS)
                waitCnt <= CNT_W'(RD_LAT - 1);
            else if (state == WAIT_RD)
                waitCnt <= waitCnt - CNT_W'(1);
            bus.mem_nEnable   <= nEnableD;
            bus.mem_ReadWrite <= readWriteD;
            bus.mem_address   <= addressD;
            bus.mem_wdata     <= wdataD;
            bus.mem_wdata_oe  <= wdataOeD;
            bus.ack0          <= ack0D;
            bus.ack1          <= ack1D;
            bus.err           <= errD;
            bus.rdata         <= rdataD;
            bus.busy          <= (nextState != IDLE);
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = selErr ? DONE : ACCESS;
            ACCESS:  nextState = curWe ? DONE : WAIT_RD;
            WAIT_RD: if (waitCnt == '0) nextState = DONE;
            default: nextState = IDLE;
        endcase
    end

    // Next-cycle pin values; ACCESS is only ever entered from IDLE, so the sel* fields apply.
    always_comb begin
        nEnableD   = 1'b1;
        readWriteD = 1'b1;
        addressD   = bus.mem_address;
        wdataD     = bus.mem_wdata;
        wdataOeD   = 1'b0;
        ack0D      = 1'b0;
        ack1D      = 1'b0;
        errD       = 1'b0;
        rdataD     = bus.rdata;
        if (nextState == ACCESS) begin
            nEnableD   = 1'b0;
            readWriteD = ~selWe;
            addressD   = selAddr;
            if (selWe) begin
                wdataD   = selWdata;
                wdataOeD = 1'b1;
            end
        end
        if (nextState == DONE) begin
            ack0D = ~donePort;
            ack1D = donePort;
            errD  = (state == IDLE);
        end
        if (state == WAIT_RD && waitCnt == '0)
            rdataD = bus.mem_rdata;
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a cycle-indexed transaction model plus directed and random traffic,
// with a second instance built for RD_LAT = 3.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int DW   = 256;
  localparam int AW   = 4;
  localparam int RDL  = 1;
  localparam int NCYC = 4096;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  mem_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus3 ();
  logic [1:0] state_dbg;
  logic [1:0] state_dbg3;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .RD_LAT(RDL)) dut (
    .clk(clk), .reset(reset), .bus(bus), .stateDbg(state_dbg));
  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(8), .RD_LAT(3)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3), .stateDbg(state_dbg3));

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0b expected %0b", name, cyc, act, exp);
  endtask

  task automatic check_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
  endtask

  // Bus-side memories; read data is only valid in the last wait cycle, garbage otherwise.
  logic [DW-1:0] bus_mem [8];
  logic [DW-1:0] bus_mem3 [8];
  int rd_cnt = 0;
  int rd_cnt3 = 0;
  logic [2:0] rd_addr, rd_addr3;

  always @(posedge clk) begin
    if (!bus.mem_nEnable && !bus.mem_ReadWrite)
      bus_mem[bus.mem_address[2:0]] = bus.mem_wdata_oe ? bus.mem_wdata : 'x;
    if (!bus.mem_nEnable && bus.mem_ReadWrite) begin
      rd_cnt = RDL;
      rd_addr = bus.mem_address[2:0];
    end
    #1;
    bus.mem_rdata = (rd_cnt == 1) ? bus_mem[rd_addr] : {8{$urandom()}};
    if (rd_cnt > 0) rd_cnt--;
  end

  always @(posedge clk) begin
    if (!bus3.mem_nEnable && !bus3.mem_ReadWrite)
      bus_mem3[bus3.mem_address[2:0]] = bus3.mem_wdata_oe ? bus3.mem_wdata : 'x;
    if (!bus3.mem_nEnable && bus3.mem_ReadWrite) begin
      rd_cnt3 = 3;
      rd_addr3 = bus3.mem_address[2:0];
    end
    #1;
    bus3.mem_rdata = (rd_cnt3 == 1) ? bus_mem3[rd_addr3] : {8{$urandom()}};
    if (rd_cnt3 > 0) rd_cnt3--;
  end

  // Model: expected pin values per cycle, derived from grant decisions and fixed latencies.
  logic e_busy [NCYC];
  logic e_nen  [NCYC];
  logic e_oe   [NCYC];
  logic e_rw   [NCYC];
  logic e_ack0 [NCYC];
  logic e_ack1 [NCYC];
  logic e_err  [NCYC];
  logic e_rdv  [NCYC];
  logic [AW-1:0] e_addr [NCYC];
  logic [DW-1:0] e_rdata [NCYC];
  logic [DW-1:0] shadow [8];
  logic [1:0] exp_q [$];
  int free_at = 0;
  logic m_last = 1'b1;

  task automatic clear_from(input int c0);
    for (int c = c0; c < NCYC; c++) begin
      e_busy[c] = 1'b0; e_nen[c] = 1'b1; e_oe[c] = 1'b0; e_rw[c] = 1'b1;
      e_ack0[c] = 1'b0; e_ack1[c] = 1'b0; e_err[c] = 1'b0; e_rdv[c] = 1'b0;
      e_addr[c] = '0; e_rdata[c] = '0;
    end
  endtask

  task automatic grant(input int k);
    logic p, w, e;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int lat;
    p = (bus.req0 && bus.req1) ? ~m_last : bus.req1;
    m_last = p;
    w = p ? bus.we1 : bus.we0;
    a = p ? bus.addr1 : bus.addr0;
    d = p ? bus.wdata1 : bus.wdata0;
    e = (int'(a) >= 8);
    lat = e ? 1 : (w ? 2 : 2 + RDL);
    if (k + lat < NCYC) begin
      for (int c = k + 1; c <= k + lat; c++) e_busy[c] = 1'b1;
      if (p) e_ack1[k + lat] = 1'b1; else e_ack0[k + lat] = 1'b1;
      e_err[k + lat] = e;
      if (!e) begin
        e_nen[k + 1] = 1'b0; e_oe[k + 1] = w; e_rw[k + 1] = ~w; e_addr[k + 1] = a;
        if (w) shadow[a[2:0]] = d;
        else begin
          e_rdv[k + lat] = 1'b1;
          e_rdata[k + lat] = shadow[a[2:0]];
        end
      end
    end
    exp_q.push_back({e, p});
    free_at = k + lat + 1;
  endtask

  always @(posedge clk) begin
    if (reset) begin
      clear_from(cyc + 1);
      if (cyc + 1 < NCYC) begin
        e_rdv[cyc + 1] = 1'b1;
        e_rdata[cyc + 1] = '0;
      end
      free_at = cyc + 1;
      m_last = 1'b1;
      exp_q.delete();
    end else if (cyc >= free_at && (bus.req0 || bus.req1)) begin
      grant(cyc);
    end
    cyc++;
  end

  logic [DW-1:0] cur_rdata = '0;
  int ack_log [$];
  logic [1:0] popped;

  always @(negedge clk) begin
    if (cyc > 0 && cyc < NCYC) begin
      if (e_rdv[cyc]) cur_rdata = e_rdata[cyc];
      check1("busy", bus.busy, e_busy[cyc]);
      check1("mem_nEnable", bus.mem_nEnable, e_nen[cyc]);
      check1("mem_wdata_oe", bus.mem_wdata_oe, e_oe[cyc]);
      check1("ack0", bus.ack0, e_ack0[cyc]);
      check1("ack1", bus.ack1, e_ack1[cyc]);
      check1("ack_exclusive", bus.ack0 & bus.ack1, 1'b0);
      check_w("rdata", bus.rdata, cur_rdata);
      if (!e_nen[cyc]) begin
        check_w("mem_address", DW'(bus.mem_address), DW'(e_addr[cyc]));
        check1("mem_ReadWrite", bus.mem_ReadWrite, e_rw[cyc]);
      end
      if (e_ack0[cyc] || e_ack1[cyc]) check1("err", bus.err, e_err[cyc]);
      if (bus.ack0 || bus.ack1) begin
        ack_log.push_back(bus.ack1 ? 1 : 0);
        check1("ack_has_pending_txn", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          popped = exp_q.pop_front();
          check_w("ack_port_err", DW'({bus.err, bus.ack1}), DW'(popped));
        end
      end
    end
  end

  // Drivers start #1 after a rising edge and return #1 after the edge that ends the ack cycle.
  task automatic drive(input int p, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       output int lat, output logic e, output logic [DW-1:0] rd);
    int c0;
    logic got;
    if (p == 0) begin bus.we0 = w; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1; end
    else        begin bus.we1 = w; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1; end
    c0 = cyc; got = 1'b0; lat = -1; e = 1'b0; rd = '0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if ((p == 0) ? bus.ack0 : bus.ack1) begin
        got = 1'b1; lat = cyc - c0; e = bus.err; rd = bus.rdata;
      end
    end
    check1("ack_within_budget", got, 1'b1);
    @(posedge clk); #1;
    if (p == 0) bus.req0 = 1'b0; else bus.req1 = 1'b0;
  endtask

  task automatic drive3(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        output int lat, output logic e, output logic [DW-1:0] rd);
    int c0;
    logic got;
    bus3.we0 = w; bus3.addr0 = a; bus3.wdata0 = d; bus3.req0 = 1'b1;
    c0 = cyc; got = 1'b0; lat = -1; e = 1'b0; rd = '0;
    for (int i = 0; i < 64 && !got; i++) begin
      @(negedge clk);
      if (bus3.ack0) begin
        got = 1'b1; lat = cyc - c0; e = bus3.err; rd = bus3.rdata;
      end
    end
    check1("lat3_ack_within_budget", got, 1'b1);
    @(posedge clk); #1;
    bus3.req0 = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  localparam logic [DW-1:0] PAT_A5 = {32{8'hA5}};
  localparam logic [DW-1:0] PAT_D1 = {8{32'h1111_0001}};
  localparam logic [DW-1:0] PAT_D2 = {8{32'h2222_0002}};
  localparam logic [DW-1:0] PAT_3C = {16{16'h3C5A}};

  initial begin
    int lat;
    logic e;
    logic [DW-1:0] rd;
    int order [4];
    order = '{0, 1, 0, 1};
    bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
    bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
    bus3.req0 = 0; bus3.req1 = 0; bus3.we0 = 0; bus3.we1 = 0;
    bus3.addr0 = '0; bus3.addr1 = '0; bus3.wdata0 = '0; bus3.wdata1 = '0;
    for (int i = 0; i < 8; i++) begin
      shadow[i] = '0; bus_mem[i] = '0; bus_mem3[i] = '0;
    end
    clear_from(0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    check1("reset_busy", bus.busy, 1'b0);
    check1("reset_nEnable", bus.mem_nEnable, 1'b1);
    check1("reset_ReadWrite", bus.mem_ReadWrite, 1'b1);
    check_w("reset_rdata", bus.rdata, '0);

    // Write then read back on port 0.
    drive(0, 1'b1, 4'd3, PAT_A5, lat, e, rd);
    check_w("t1_write_latency", DW'(lat), DW'(2));
    drive(0, 1'b0, 4'd3, '0, lat, e, rd);
    check_w("t1_read_latency", DW'(lat), DW'(3));
    check_w("t1_read_data", rd, PAT_A5);
    check1("t1_read_err", e, 1'b0);

    // Saturated contention straight after reset.
    do_reset();
    ack_log.delete();
    fork
      begin : port0_traffic
        int l0; logic e0; logic [DW-1:0] r0;
        drive(0, 1'b1, 4'd1, PAT_D1, l0, e0, r0);
        drive(0, 1'b1, 4'd2, PAT_D2, l0, e0, r0);
      end
      begin : port1_traffic
        int l1; logic e1; logic [DW-1:0] r1;
        drive(1, 1'b0, 4'd3, '0, l1, e1, r1);
        check_w("t2_port1_read_data", r1, PAT_A5);
        drive(1, 1'b0, 4'd3, '0, l1, e1, r1);
      end
    join
    check_w("t2_ack_count", DW'(ack_log.size()), DW'(4));
    for (int i = 0; i < 4 && i < ack_log.size(); i++)
      check_w("t2_grant_order", DW'(ack_log[i]), DW'(order[i]));

    // Out-of-range read on port 1.
    drive(1, 1'b0, 4'd9, '0, lat, e, rd);
    check_w("t3_err_latency", DW'(lat), DW'(1));
    check1("t3_err_flag", e, 1'b1);
    check_w("t3_rdata_unchanged", rd, PAT_A5);

    // Reset during the read wait cycle.
    bus.we0 = 1'b0; bus.addr0 = 4'd3; bus.req0 = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check1("t4_wait_busy", bus.busy, 1'b1);
    check1("t4_wait_nEnable", bus.mem_nEnable, 1'b1);
    reset = 1'b1; bus.req0 = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    check1("t4_busy", bus.busy, 1'b0);
    check1("t4_ack0", bus.ack0, 1'b0);
    check1("t4_err", bus.err, 1'b0);
    check_w("t4_rdata", bus.rdata, '0);
    check1("t4_nEnable", bus.mem_nEnable, 1'b1);
    check1("t4_ReadWrite", bus.mem_ReadWrite, 1'b1);
    check_w("t4_address", DW'(bus.mem_address), '0);
    check_w("t4_wdata", bus.mem_wdata, '0);
    check1("t4_wdata_oe", bus.mem_wdata_oe, 1'b0);
    drive(0, 1'b0, 4'd3, '0, lat, e, rd);
    check_w("t4_fresh_read_latency", DW'(lat), DW'(3));
    check_w("t4_fresh_read_data", rd, PAT_A5);

    // Random mix on both ports, checked against the model every cycle.
    fork
      begin : rand0
        int l0, g0; logic e0, w0; logic [DW-1:0] r0; logic [AW-1:0] a0;
        for (int i = 0; i < 100; i++) begin
          g0 = $urandom_range(0, 2);
          if (g0 > 0) begin repeat (g0) @(posedge clk); #1; end
          w0 = 1'($urandom_range(0, 1)); a0 = AW'($urandom_range(0, 9));
          drive(0, w0, a0, {8{$urandom()}}, l0, e0, r0);
        end
      end
      begin : rand1
        int l1, g1; logic e1, w1; logic [DW-1:0] r1; logic [AW-1:0] a1;
        for (int i = 0; i < 100; i++) begin
          g1 = $urandom_range(0, 2);
          if (g1 > 0) begin repeat (g1) @(posedge clk); #1; end
          w1 = 1'($urandom_range(0, 1)); a1 = AW'($urandom_range(0, 9));
          drive(1, w1, a1, {8{$urandom()}}, l1, e1, r1);
        end
      end
    join

    // RD_LAT = 3 instance.
    drive3(1'b1, 4'd5, PAT_3C, lat, e, rd);
    check_w("t6_write_latency", DW'(lat), DW'(2));
    drive3(1'b0, 4'd5, '0, lat, e, rd);
    check_w("t6_read_latency", DW'(lat), DW'(5));
    check_w("t6_read_data", rd, PAT_3C);
    check1("t6_read_err", e, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    check_w("all_txns_acked", DW'(exp_q.size()), '0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
